// File: rtl/kbd_pkg.sv
// Shared keyboard-path constants: Set-2 scan codes and ASCII values
// used by the scan-code translator and its neighbours.
package kbd_pkg;

  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_ENTER = 8'h5A;
  localparam logic [7:0] SC_BKSP  = 8'h66;
  localparam logic [7:0] SC_SPACE = 8'h29;
  localparam logic [7:0] SC_TAB   = 8'h0D;
  localparam logic [7:0] SC_ESC   = 8'h76;

  localparam logic [7:0] ASC_NUL  = 8'h00;
  localparam logic [7:0] ASC_BS   = 8'h08;
  localparam logic [7:0] ASC_TAB  = 8'h09;
  localparam logic [7:0] ASC_CR   = 8'h0D;
  localparam logic [7:0] ASC_ESC  = 8'h1B;
  localparam logic [7:0] ASC_SP   = 8'h20;

endpackage

// File: rtl/scancode_lut.sv
// Combinational Set-2 make code to unshifted ASCII lookup.
// Prefix bytes and anything not listed fall through to UNMAPPED.
module scancode_lut
  import kbd_pkg::*;
#(
  parameter logic [7:0] UNMAPPED = 8'h00
) (
  input  logic [7:0] code_i,
  output logic [7:0] ascii_o
);

  always_comb begin
    ascii_o = UNMAPPED;
    case (code_i)
      8'h1C: ascii_o = 8'h61;
      8'h32: ascii_o = 8'h62;
      8'h21: ascii_o = 8'h63;
      8'h23: ascii_o = 8'h64;
      8'h24: ascii_o = 8'h65;
      8'h2B: ascii_o = 8'h66;
      8'h34: ascii_o = 8'h67;
      8'h33: ascii_o = 8'h68;
      8'h43: ascii_o = 8'h69;
      8'h3B: ascii_o = 8'h6A;
      8'h42: ascii_o = 8'h6B;
      8'h4B: ascii_o = 8'h6C;
      8'h3A: ascii_o = 8'h6D;
      8'h31: ascii_o = 8'h6E;
      8'h44: ascii_o = 8'h6F;
      8'h4D: ascii_o = 8'h70;
      8'h15: ascii_o = 8'h71;
      8'h2D: ascii_o = 8'h72;
      8'h1B: ascii_o = 8'h73;
      8'h2C: ascii_o = 8'h74;
      8'h3C: ascii_o = 8'h75;
      8'h2A: ascii_o = 8'h76;
      8'h1D: ascii_o = 8'h77;
      8'h22: ascii_o = 8'h78;
      8'h35: ascii_o = 8'h79;
      8'h1A: ascii_o = 8'h7A;
      // digit row
      8'h45: ascii_o = 8'h30;
      8'h16: ascii_o = 8'h31;
      8'h1E: ascii_o = 8'h32;
      8'h26: ascii_o = 8'h33;
      8'h25: ascii_o = 8'h34;
      8'h2E: ascii_o = 8'h35;
      8'h36: ascii_o = 8'h36;
      8'h3D: ascii_o = 8'h37;
      8'h3E: ascii_o = 8'h38;
      8'h46: ascii_o = 8'h39;
      SC_SPACE: ascii_o = ASC_SP;
      SC_ENTER: ascii_o = ASC_CR;
      SC_BKSP:  ascii_o = ASC_BS;
      SC_TAB:   ascii_o = ASC_TAB;
      SC_ESC:   ascii_o = ASC_ESC;
      8'h0E: ascii_o = 8'h60;
      8'h4E: ascii_o = 8'h2D;
      8'h55: ascii_o = 8'h3D;
      8'h54: ascii_o = 8'h5B;
      8'h5B: ascii_o = 8'h5D;
      8'h5D: ascii_o = 8'h5C;
      8'h4C: ascii_o = 8'h3B;
      8'h52: ascii_o = 8'h27;
      8'h41: ascii_o = 8'h2C;
      8'h49: ascii_o = 8'h2E;
      8'h4A: ascii_o = 8'h2F;
      // E0 context is not tracked; the following byte translates as a plain code
      SC_BREAK, SC_EXT: ascii_o = UNMAPPED;
      default: ascii_o = UNMAPPED;
    endcase
  end

endmodule

// File: rtl/data_to_ascii.sv
// Registered PS/2 Set-2 to ASCII translator: lookup plus one output flop.
// Reset forces NUL regardless of UNMAPPED.
module data_to_ascii
  import kbd_pkg::*;
#(
  parameter logic [7:0] UNMAPPED = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] code,
  output logic [7:0] ascii
);

  logic [7:0] ascii_d;
  logic [7:0] ascii_q;

  scancode_lut #(
    .UNMAPPED(UNMAPPED)
  ) u_lut (
    .code_i (code),
    .ascii_o(ascii_d)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ascii_q <= ASC_NUL;
    end else begin
      ascii_q <= ascii_d;
    end
  end

  assign ascii = ascii_q;

endmodule

// File: tb/tb_data_to_ascii.sv
// Directed bench for data_to_ascii: reset behaviour, latency, table sweep,
// unmapped codes and asynchronous mid-stream reset.
module tb_data_to_ascii;

  logic       clk;
  logic       rst;
  logic [7:0] code;
  logic [7:0] ascii;

  int n_checks = 0;
  int n_errors = 0;

  // {scan code, expected ASCII}, written out by hand from the key table
  localparam int N_TBL = 52;
  logic [15:0] tbl [N_TBL] = '{
    16'h1C61, 16'h3262, 16'h2163, 16'h2364, 16'h2465, 16'h2B66, 16'h3467,
    16'h3368, 16'h4369, 16'h3B6A, 16'h426B, 16'h4B6C, 16'h3A6D, 16'h316E,
    16'h446F, 16'h4D70, 16'h1571, 16'h2D72, 16'h1B73, 16'h2C74, 16'h3C75,
    16'h2A76, 16'h1D77, 16'h2278, 16'h3579, 16'h1A7A,
    16'h4530, 16'h1631, 16'h1E32, 16'h2633, 16'h2534, 16'h2E35, 16'h3636,
    16'h3D37, 16'h3E38, 16'h4639,
    16'h2920, 16'h5A0D, 16'h6608, 16'h0D09, 16'h761B,
    16'h0E60, 16'h4E2D, 16'h553D, 16'h545B, 16'h5B5D, 16'h5D5C, 16'h4C3B,
    16'h5227, 16'h412C, 16'h492E, 16'h4A2F
  };

  data_to_ascii #(.UNMAPPED(8'h00)) dut (
    .clk  (clk),
    .rst  (rst),
    .code (code),
    .ascii(ascii)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got %02h expected %02h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [7:0] ref_ascii(input logic [7:0] c);
    logic [15:0] e;
    ref_ascii = 8'h00;
    for (int k = 0; k < N_TBL; k++) begin
      e = tbl[k];
      if (e[15:8] == c) ref_ascii = e[7:0];
    end
  endfunction

  initial begin
    logic [15:0] e;
    logic [7:0] seq_c [4];
    logic [7:0] seq_a [4];

    rst  = 1'b1;
    code = 8'h1C;
    #2;
    check8("reset_no_edge", ascii, 8'h00);
    #5;
    check8("reset_through_edge", ascii, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check8("release_no_glitch", ascii, 8'h00);
    @(negedge clk);
    check8("first_edge_a", ascii, 8'h61);

    // consecutive codes, one new result per cycle lagging by one
    @(negedge clk) code = 8'h00;
    @(negedge clk);
    check8("pre_pipe_nul", ascii, 8'h00);
    seq_c = '{8'h1C, 8'h45, 8'h29, 8'h5A};
    seq_a = '{8'h61, 8'h30, 8'h20, 8'h0D};
    code = seq_c[0];
    #1;
    check8("pipe_lag", ascii, 8'h00);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check8($sformatf("pipe_%0d", i), ascii, seq_a[i]);
      if (i < 3) code = seq_c[i + 1];
    end

    // every listed entry
    for (int k = 0; k < N_TBL; k++) begin
      e = tbl[k];
      code = e[15:8];
      @(negedge clk);
      check8($sformatf("tbl_%02h", e[15:8]), ascii, e[7:0]);
    end

    // all 256 codes
    for (int c = 0; c < 256; c++) begin
      code = 8'(c);
      @(negedge clk);
      check8($sformatf("sweep_%02h", c), ascii, ref_ascii(8'(c)));
    end

    // press / release
    seq_c = '{8'h1C, 8'hF0, 8'h1C, 8'hE0};
    seq_a = '{8'h61, 8'h00, 8'h61, 8'h00};
    for (int i = 0; i < 4; i++) begin
      code = seq_c[i];
      @(negedge clk);
      check8($sformatf("press_rel_%0d", i), ascii, seq_a[i]);
    end

    // async reset pulse between edges with code held
    code = 8'h1A;
    @(negedge clk);
    check8("hold_z", ascii, 8'h7A);
    #1 rst = 1'b1;
    #1;
    check8("midrst_clear", ascii, 8'h00);
    #1 rst = 1'b0;
    #1;
    check8("midrst_hold", ascii, 8'h00);
    @(negedge clk);
    check8("midrst_recover", ascii, 8'h7A);

    // reset landing on a changing code discards the pending value
    code = 8'h45;
    #1 rst = 1'b1;
    @(negedge clk);
    check8("rst_over_edge", ascii, 8'h00);
    rst = 1'b0;
    @(negedge clk);
    check8("rst_over_edge_recover", ascii, 8'h30);

    // steady code: no toggling
    code = 8'h1C;
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check8($sformatf("stable_%0d", i), ascii, 8'h61);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
